// File: rtl/alu_issue_decoder.sv
// Registered RV64I issue stage: decodes instruction + register data into ALU operands/opcode,
// with a 2-entry skid buffer behind a valid/ready handshake. Optional flush via ALU_ISSUE_FLUSH_EN.
module alu_issue_decoder #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            reset,
`ifdef ALU_ISSUE_FLUSH_EN
    input  logic            out_flush,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_operand1,
    output logic [XLEN-1:0] out_operand2,
    output logic [3:0]      out_alu_op,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [3:0]      op;
        logic            ill;
    } entry_t;

    logic flush;
`ifdef ALU_ISSUE_FLUSH_EN
    assign flush = out_flush;
`else
    assign flush = 1'b0;
`endif

    // alt selects the SUB/SRA variant of the funct3 operation
    function automatic logic [3:0] funct3_op(input logic [2:0] f3, input logic alt);
        logic [3:0] r;
        r = ALU_ADD;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            3'b111:  r = ALU_AND;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic            dec_legal;
    entry_t          dec;

    always_comb begin
        opcode    = in_inst[6:0];
        funct3    = in_inst[14:12];
        funct7    = in_inst[31:25];
        imm_i     = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
        imm_s     = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        imm_u     = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
        dec_legal = 1'b1;
        dec       = '0;
        case (opcode)
            OPC_OP: begin
                dec.op1 = in_rs1_data;
                dec.op2 = in_rs2_data;
                dec.op  = funct3_op(funct3, in_inst[30]);
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    dec_legal = 1'b0;
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 != 3'b000 && funct3 != 3'b101) dec_legal = 1'b0;
                end else if (funct7 != 7'b0000000) begin
                    dec_legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec.op1 = in_rs1_data;
                dec.op2 = imm_i;
                dec.op  = funct3_op(funct3, in_inst[30] && (funct3 == 3'b101));
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    dec_legal = 1'b0;
                end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.op2 = {{(XLEN-6){1'b0}}, in_inst[25:20]};
                    if (in_inst[31:26] != 6'b000000 && in_inst[31:26] != 6'b010000) dec_legal = 1'b0;
                end
            end
            OPC_LOAD: begin
                dec.op1 = in_rs1_data;
                dec.op2 = imm_i;
            end
            OPC_STORE: begin
                dec.op1 = in_rs1_data;
                dec.op2 = imm_s;
            end
            OPC_LUI: begin
                dec.op2 = imm_u;
            end
            OPC_AUIPC: begin
                dec.op1 = in_pc;
                dec.op2 = imm_u;
            end
            default: dec_legal = 1'b0;
        endcase
        // illegal entries carry no operand data so the ALU sees a benign ADD 0,0
        if (!dec_legal) begin
            dec     = '0;
            dec.ill = 1'b1;
        end
    end

    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   accept;
    logic   transfer;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign transfer = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end
        end else if (transfer) begin
            // skid full implies in_ready low, so accept cannot coincide with a skid drain
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = dec;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid    = main_valid_q;
    assign out_operand1 = main_q.op1;
    assign out_operand2 = main_q.op2;
    assign out_alu_op   = main_q.op;
    assign out_illegal  = main_q.ill;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Self-checking bench for alu_issue_decoder: directed cases plus randomized traffic checked
// against a FIFO-of-expected-entries model. Build with ALU_ISSUE_FLUSH_EN to exercise flush.
module tb_alu_issue_decoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        out_flush;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic [63:0] in_rs1_data;
    logic [63:0] in_rs2_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_illegal;
    logic [63:0] out_operand1;
    logic [63:0] out_operand2;
    logic [3:0]  out_alu_op;

    alu_issue_decoder dut (
        .clk          (clk),
        .reset        (reset),
`ifdef ALU_ISSUE_FLUSH_EN
        .out_flush    (out_flush),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_operand1 (out_operand1),
        .out_operand2 (out_operand2),
        .out_alu_op   (out_alu_op),
        .out_illegal  (out_illegal)
    );

    typedef struct packed {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic last_acc;
    logic last_xfer;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Operation named by funct3, with alt choosing SUB/SRA
    function automatic logic [3:0] op_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? 4'd1 : 4'd0;
            3'd1:    return 4'd5;
            3'd4:    return 4'd4;
            3'd5:    return alt ? 4'd7 : 4'd6;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [63:0] pc,
                                        input logic [63:0] r1, input logic [63:0] r2);
        exp_t e;
        logic signed [63:0] immi;
        logic signed [63:0] imms;
        logic signed [63:0] immu;
        logic [2:0] f3;
        logic [6:0] f7;
        immi = $signed(i[31:20]);
        imms = $signed({i[31:25], i[11:7]});
        immu = $signed({i[31:12], 12'h000});
        f3 = i[14:12];
        f7 = i[31:25];
        e = '0;
        case (i[6:0])
            7'h33: begin
                e.op1 = r1; e.op2 = r2;
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
                else if (f7 == 7'h00) e.op = op_of(f3, 1'b0);
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.op = op_of(f3, 1'b1);
                else e.ill = 1'b1;
            end
            7'h13: begin
                e.op1 = r1;
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
                else if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.op2 = 64'(i[25:20]);
                    e.op  = op_of(f3, i[30]);
                    if (i[31:26] != 6'd0 && i[31:26] != 6'b010000) e.ill = 1'b1;
                end else begin
                    e.op2 = immi;
                    e.op  = op_of(f3, 1'b0);
                end
            end
            7'h03: begin e.op1 = r1; e.op2 = immi; end
            7'h23: begin e.op1 = r1; e.op2 = imms; end
            7'h37: begin e.op2 = immu; end
            7'h17: begin e.op1 = pc; e.op2 = immu; end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // One clock: check outputs against the model at the falling edge, then advance the model.
    task automatic tick();
        exp_t e;
        logic do_flush;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("operand1", out_operand1, q[0].op1);
            chk("operand2", out_operand2, q[0].op2);
            chk("alu_op", 64'(out_alu_op), 64'(q[0].op));
            chk("illegal", 64'(out_illegal), 64'(q[0].ill));
        end
        last_acc  = in_valid && in_ready;
        last_xfer = out_valid && out_ready;
`ifdef ALU_ISSUE_FLUSH_EN
        do_flush = out_flush;
`else
        do_flush = 1'b0;
`endif
        e = ref_decode(in_inst, in_pc, in_rs1_data, in_rs2_data);
        @(posedge clk);
        #1;
        if (do_flush) begin
            q.delete();
            last_acc = 1'b0;
        end else begin
            if (last_xfer) void'(q.pop_front());
            if (last_acc) q.push_back(e);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] op, input logic [63:0] a,
                              input logic [63:0] b, input logic ill);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_op"}, 64'(out_alu_op), 64'(op));
        chk({tag, "_op1"}, out_operand1, a);
        chk({tag, "_op2"}, out_operand2, b);
        chk({tag, "_ill"}, 64'(out_illegal), 64'(ill));
    endtask

    task automatic issue_one(input logic [31:0] inst, input logic [63:0] pc,
                             input logic [63:0] r1, input logic [63:0] r2);
        in_inst = inst; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int xfers;
        int guard;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; out_flush = 1'b0;
        in_inst = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
        last_acc = 1'b0; last_xfer = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_op1", out_operand1, 64'd0);
        chk("rst_op", 64'(out_alu_op), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue_one(32'h002081B3, 64'h0, 64'd5, 64'd7);
        expect_out("add", 4'd0, 64'd5, 64'd7, 1'b0);
        issue_one(32'h402081B3, 64'h0, 64'd9, 64'd4);
        expect_out("sub", 4'd1, 64'd9, 64'd4, 1'b0);
        issue_one(32'h4030D093, 64'h0, -64'sd16, 64'd0);
        expect_out("srai", 4'd7, -64'sd16, 64'd3, 1'b0);
        issue_one(32'h800002B7, 64'h0, 64'h1234, 64'h5678);
        expect_out("lui", 4'd0, 64'd0, 64'hFFFFFFFF80000000, 1'b0);
        issue_one(32'h80000297, 64'h1000, 64'h1234, 64'h5678);
        expect_out("auipc", 4'd0, 64'h1000, 64'hFFFFFFFF80000000, 1'b0);
        issue_one(32'h0020A1B3, 64'h0, 64'd3, 64'd4);
        expect_out("slt", 4'd0, 64'd0, 64'd0, 1'b1);
        tick();
        chk("slt_done", 64'(out_valid), 64'd0);

        // Backpressure: A, B fill both entries, C is held upstream
        out_ready = 1'b0;
        issue_one(32'h002081B3, 64'h0, 64'hA, 64'h1);
        issue_one(32'h0020C1B3, 64'h0, 64'hB, 64'h2);
        chk("bp_in_ready_after_B", 64'(in_ready), 64'd0);
        in_inst = 32'h0020E1B3; in_rs1_data = 64'hC; in_rs2_data = 64'h3; in_valid = 1'b1;
        tick();
        chk("bp_C_held", 64'(last_acc), 64'd0);
        tick();
        out_ready = 1'b1;
        xfers = 0;
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            tick();
            if (last_acc) in_valid = 1'b0;
            if (last_xfer) xfers++;
            guard++;
        end
        chk("bp_three_out", 64'(xfers), 64'd3);
        chk("bp_cycles", 64'(guard), 64'd3);

        // Async reset with two entries held
        out_ready = 1'b0;
        issue_one(32'h002081B3, 64'h0, 64'd1, 64'd2);
        issue_one(32'h002081B3, 64'h0, 64'd3, 64'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_op1", out_operand1, 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifdef ALU_ISSUE_FLUSH_EN
        issue_one(32'h002081B3, 64'h0, 64'd1, 64'd2);
        issue_one(32'h002081B3, 64'h0, 64'd3, 64'd4);
        out_flush = 1'b1;
        in_valid = 1'b1;
        tick();
        out_flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
`endif

        // Randomized traffic; upstream holds its offer until accepted
        begin
            logic [6:0] opcs [7];
            logic [6:0] f7s  [3];
            logic [31:0] inst;
            opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h00};
            f7s  = '{7'h00, 7'h20, 7'h00};
            last_acc = 1'b1;
            for (int n = 0; n < 400; n++) begin
                if (!(in_valid && !last_acc)) begin
                    inst = $urandom;
                    inst[6:0] = opcs[$urandom_range(6)];
                    if (inst[6:0] == 7'h00) inst[6:0] = 7'($urandom);
                    f7s[2] = 7'($urandom);
                    inst[31:25] = f7s[$urandom_range(2)];
                    in_inst = inst;
                    in_pc = {$urandom, $urandom};
                    in_rs1_data = {$urandom, $urandom};
                    in_rs2_data = {$urandom, $urandom};
                    in_valid = ($urandom_range(3) != 0);
                end
                out_ready = ($urandom_range(2) != 0);
                tick();
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            repeat (3) tick();
            chk("drain_empty", 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
